// File: rtl/alu_issue_stage.sv
// Issue stage around a combinational ALU: command FIFO in front, result register behind.
// Optional build macro ALU_RESULT_PARITY_EN adds a registered res_parity output.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [4:0]                 cmd_op,
  input  logic                       cmd_sel,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [4:0]                 alu_op,
  output logic                       alu_sel,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_flag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic                       res_flag,
  output logic [4:0]                 res_op,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           done_cnt
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic                       res_parity
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

  logic [WIDTH-1:0] mem_a_q   [DEPTH];
  logic [WIDTH-1:0] mem_b_q   [DEPTH];
  logic [4:0]       mem_op_q  [DEPTH];
  logic             mem_sel_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_flag_q, res_flag_d;
  logic [4:0]       res_op_q, res_op_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic handoff;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign res_valid = (state_q == OUT_FULL);
  // Pop only when the result register is free or being drained this cycle.
  assign pop       = !empty && (!res_valid || res_ready);
  assign handoff   = res_valid && res_ready;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    alu_sel = 1'b0;
    if (!empty) begin
      alu_a   = mem_a_q[rd_ptr_q];
      alu_b   = mem_b_q[rd_ptr_q];
      alu_op  = mem_op_q[rd_ptr_q];
      alu_sel = mem_sel_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]   <= cmd_a;
      mem_b_q[wr_ptr_q]   <= cmd_b;
      mem_op_q[wr_ptr_q]  <= cmd_op;
      mem_sel_q[wr_ptr_q] <= cmd_sel;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_flag_d = res_flag_q;
    res_op_d   = res_op_q;
    done_cnt_d = done_cnt_q;
    if (handoff) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
    case (state_q)
      OUT_EMPTY: begin
        if (pop) begin
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (!pop && res_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
    if (pop) begin
      res_data_d = alu_result;
      res_flag_d = alu_flag;
      res_op_d   = alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= OUT_EMPTY;
      res_data_q <= '0;
      res_flag_q <= 1'b0;
      res_op_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_flag_q <= res_flag_d;
      res_op_q   <= res_op_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign res_data   = res_data_q;
  assign res_flag   = res_flag_q;
  assign res_op     = res_op_q;
  assign fifo_level = level_q;
  assign done_cnt   = done_cnt_q;

`ifdef ALU_RESULT_PARITY_EN
  logic res_parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_parity_q <= 1'b0;
    end else if (pop) begin
      res_parity_q <= ^alu_result;
    end
  end

  assign res_parity = res_parity_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage with a queue-based reference model.
module tb_alu_issue_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [4:0]       cmd_op;
  logic             cmd_sel;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [4:0]       alu_op;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_flag;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_flag;
  logic [4:0]       res_op;
  logic [2:0]       fifo_level;
  logic [CNT_W-1:0] done_cnt;
`ifdef ALU_RESULT_PARITY_EN
  logic             res_parity;
`endif

  always #5 clk = ~clk;

  assign alu_result = alu_a + alu_b;
  assign alu_flag   = alu_sel;

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flag(res_flag), .res_op(res_op),
    .fifo_level(fifo_level), .done_cnt(done_cnt)
`ifdef ALU_RESULT_PARITY_EN
    , .res_parity(res_parity)
`endif
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of commands plus one result slot.
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       op;
    logic             sel;
  } cmd_t;

  cmd_t             m_q[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_flag;
  logic [4:0]       m_op;
  int               m_cnt;

  always @(posedge clk or negedge rst_n) begin : model
    bit   acc, hand, adv;
    cmd_t h;
    if (!rst_n) begin
      m_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_flag  = 1'b0;
      m_op    = '0;
      m_cnt   = 0;
    end else begin
      acc  = cmd_valid && (m_q.size() != DEPTH);
      hand = m_valid && res_ready;
      adv  = (m_q.size() != 0) && (!m_valid || res_ready);
      if (hand) m_cnt++;
      if (adv) begin
        h       = m_q.pop_front();
        m_data  = h.a + h.b;
        m_flag  = h.sel;
        m_op    = h.op;
        m_valid = 1'b1;
      end else if (hand) begin
        m_valid = 1'b0;
      end
      if (acc) m_q.push_back('{cmd_a, cmd_b, cmd_op, cmd_sel});
    end
  end

  always @(posedge clk) begin : compare
    #1;
    if (chk_en && rst_n) begin
      check("cmd_ready", cmd_ready, (m_q.size() != DEPTH));
      check("fifo_level", fifo_level, m_q.size());
      check("res_valid", res_valid, m_valid);
      check("res_data", res_data, m_data);
      check("res_flag", res_flag, m_flag);
      check("res_op", res_op, m_op);
      check("done_cnt", done_cnt, m_cnt % (1 << CNT_W));
      check("alu_a", alu_a, (m_q.size() != 0) ? m_q[0].a : '0);
      check("alu_b", alu_b, (m_q.size() != 0) ? m_q[0].b : '0);
      check("alu_op", alu_op, (m_q.size() != 0) ? m_q[0].op : '0);
      check("alu_sel", alu_sel, (m_q.size() != 0) ? m_q[0].sel : 1'b0);
`ifdef ALU_RESULT_PARITY_EN
      check("res_parity", res_parity, ^m_data);
`endif
    end
  end

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [4:0] op, input logic sel);
    int t;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_sel = sel;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready) begin
      @(negedge clk);
      t++;
      if (t > 50) begin
        check("push_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    check("rst_res_valid", res_valid, 1'b0);
    check("rst_fifo_level", fifo_level, 3'd0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_done_cnt", done_cnt, 4'd0);
    check("rst_res_data", res_data, 32'd0);

    // Single command: 5+7 appears two edges after acceptance.
    res_ready = 1'b1;
    push(32'd5, 32'd7, 5'd0, 1'b0);
    @(negedge clk);
    check("lat_res_valid", res_valid, 1'b1);
    check("lat_res_data", res_data, 32'd12);
    check("lat_res_flag", res_flag, 1'b0);
    check("lat_res_op", res_op, 5'd0);
    @(negedge clk);
    check("lat_done_cnt", done_cnt, 4'd1);
    check("lat_res_valid_clr", res_valid, 1'b0);

    // Backpressure: one held in the result register, four queued.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'(100 * (i + 1)), 32'(i), 5'(i + 3), i[0]);
    check("bp_level", fifo_level, 3'd4);
    check("bp_cmd_ready", cmd_ready, 1'b0);
    check("bp_res_data", res_data, 32'd100);
    cmd_a = 32'hdead; cmd_b = 32'h1; cmd_op = 5'd31; cmd_sel = 1'b1;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_hold_data", res_data, 32'd100);
    res_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("bp_done_cnt", done_cnt, 4'd6);

    // Streaming with alternating sel.
    for (int i = 0; i < 20; i++) begin
      cmd_a = $urandom; cmd_b = $urandom; cmd_op = 5'($urandom); cmd_sel = i[0];
      cmd_valid = 1'b1;
      @(negedge clk);
      check("stream_level_le1", fifo_level <= 3'd1, 1'b1);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom % 4) != 0;
      res_ready = ($urandom % 3) != 0;
      cmd_a = $urandom; cmd_b = $urandom; cmd_op = 5'($urandom); cmd_sel = 1'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (8) @(negedge clk);

    // Counter wrap: 17 results on a 4-bit counter.
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(32'(i), 32'd1, 5'd2, 1'b0);
    repeat (4) @(negedge clk);
    check("wrap_done_cnt", done_cnt, 4'd1);

    // Asynchronous reset with a result pending and three queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(i + 1), 32'd9, 5'd1, 1'b1);
    check("pre_rst_valid", res_valid, 1'b1);
    check("pre_rst_level", fifo_level, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res_valid", res_valid, 1'b0);
    check("arst_level", fifo_level, 3'd0);
    check("arst_cmd_ready", cmd_ready, 1'b1);
    check("arst_res_data", res_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef ALU_RESULT_PARITY_EN
    res_ready = 1'b1;
    push(32'd1, 32'd2, 5'd0, 1'b0);
    @(negedge clk);
    check("par_data3", res_data, 32'd3);
    check("par_bit3", res_parity, 1'b0);
    push(32'd1, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("par_data1", res_data, 32'd1);
    check("par_bit1", res_parity, 1'b1);
    repeat (2) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream/downstream wrapper stage around the combinational ALU (alu_top).
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Presents the FIFO head to the ALU inputs, then registers the ALU result and flag into an output register with its own valid/ready handshake.
- Decouples command producers from result consumers so the combinational ALU sits between two register boundaries.

Parameters:
- WIDTH, 32, operand/result width; must match the alu_top WIDTH.
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_op  in  5  ALU opcode.
- cmd_sel  in  1  0 selects math, 1 selects logic.
- alu_a  out  WIDTH  to ALU alu_a.
- alu_b  out  WIDTH  to ALU alu_b.
- alu_op  out  5  to ALU alu_op.
- alu_sel  out  1  to ALU alu_sel.
- alu_result  in  WIDTH  from ALU result.
- alu_flag  in  1  from ALU flag.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  captured result.
- res_flag  out  1  captured flag.
- res_op  out  5  opcode that produced res_data.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- done_cnt  out  CNT_W  count of results handed off.

Behaviour:
- Clocking: single clock domain. Reset is asynchronous and active-low, named rst_n; clock is clk.
- Reset values:
  - FIFO pointers and level 0, so cmd_ready=1.
  - res_valid=0, res_data=0, res_flag=0, res_op=0, done_cnt=0.
  - FIFO storage is not reset.
- Push: on cmd_valid && cmd_ready, write {a,b,op,sel} at the write pointer.
- cmd_ready = (level != DEPTH). No push-while-full bypass: when full, cmd_ready=0 even if a pop occurs in the same cycle.
- ALU drive (combinational from FIFO storage and read pointer):
  - Non-empty: alu_* = head entry.
  - Empty: alu_* = all zeros.
- Output register states:
  - OUT_EMPTY: res_valid=0.
  - OUT_FULL: res_valid=1.
- advance = (level != 0) && (!res_valid || res_ready).
- On advance, in one edge:
  - pop the head;
  - res_data<=alu_result, res_flag<=alu_flag, res_op<=head op;
  - res_valid<=1.
- Result accepted with no advance (res_valid && res_ready && level==0): res_valid<=0 and res_* hold their values.
- Result register full and res_ready=0: res_* hold stable, no pop occurs, and alu_* keep showing the head.
- done_cnt increments on every res_valid && res_ready. It wraps modulo 2^CNT_W with no saturation.
- Simultaneous push and pop when not full: level unchanged, both pointers advance. Pointers wrap at DEPTH.
- Throughput: one result per cycle with res_ready held 1.
- Latency: command accepted at edge N appears with res_valid=1 after edge N+1 (FIFO write, then capture). There is no same-cycle bypass.
- Reset mid-operation: FIFO contents are discarded and any pending result is dropped; outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro ALU_RESULT_PARITY_EN.
- Defined:
  - adds output res_parity (1 bit) = even parity (XOR reduce) of res_data;
  - res_parity is registered alongside res_data and reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- In all scenarios the bench connects a stub ALU with alu_result = alu_a + alu_b and alu_flag = alu_sel.
- After reset release with res_ready=1, push a=5, b=7, op=0, sel=0 → two edges later res_valid=1, res_data=12, res_flag=0, res_op=0; done_cnt=1 one edge later.
- Hold res_ready=0 and push 5 commands → cmd_ready falls after 4 accepted while the first is held in res_*; fifo_level=4 while the result register is full. Raise res_ready → results emerge in order with no drop or duplicate, one per cycle.
- Push and consume continuously with sel alternating 0/1 → res_flag alternates matching sel; fifo_level stays ≤1; throughput is 1/cycle.
- Preload done_cnt near wrap (CNT_W=4, 17 results) → done_cnt reads 1.
- Assert rst_n low mid-stream with 3 entries queued and res_valid=1 → res_valid=0 and fifo_level=0 without waiting for a clock edge; cmd_ready=1.
- With ALU_RESULT_PARITY_EN defined, push a=1, b=2 → res_data=3, res_parity=0; push a=1, b=0 → res_parity=1.
